mac: RTL and testbench

MAC -- requirements
Module: mac

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_sat_add.sv | 47 ++++
 rtl/mac.sv | 46 ++++
 tb/tb_mac.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, accumulator limits and overflow classification for the mac block.
package mac_pkg;

    localparam int unsigned ACC_W_DEFAULT = 16;
    localparam int unsigned WGT_W_DEFAULT = 8;

    localparam logic signed [ACC_W_DEFAULT-1:0] ACC_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
    localparam logic signed [ACC_W_DEFAULT-1:0] ACC_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

    typedef enum logic [1:0] {
        OVF_NONE,
        OVF_POS,
        OVF_NEG
    } ovf_kind_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational weight add: sign extension, ACC_W+1-bit sum, overflow detection,
// and saturate (MAC_SAT_EN defined) or wrap (default) result selection.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT,
    parameter int unsigned WGT_W = WGT_W_DEFAULT
) (
    input  logic                    en,
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [WGT_W-1:0] weight,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] wgt_ext;
    logic signed [ACC_W:0]   sum_full;
    ovf_kind_e               kind;

    // With en low the addend is zero, so no overflow can be reported.
    always_comb begin
        wgt_ext  = en ? ACC_W'(weight) : '0;
        sum_full = (ACC_W+1)'(acc) + (ACC_W+1)'(wgt_ext);
        kind     = OVF_NONE;
        if (sum_full[ACC_W] != sum_full[ACC_W-1]) begin
            kind = sum_full[ACC_W] ? OVF_NEG : OVF_POS;
        end
    end

    assign ovf = (kind != OVF_NONE);

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        case (kind)
            OVF_POS: sum = SAT_MAX;
            OVF_NEG: sum = SAT_MIN;
            default: sum = sum_full[ACC_W-1:0];
        endcase
    end
`else
    assign sum = sum_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac.sv
// Spike-driven multiply-accumulate stage with one-cycle registered output.
// Optional saturation is enabled by defining MAC_SAT_EN.
module mac
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT,
    parameter int unsigned WGT_W = WGT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spike_in,
    input  logic signed [WGT_W-1:0] weight,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    ovf
);

    if (WGT_W > ACC_W) begin : g_width_check
        $error("mac: WGT_W must not exceed ACC_W");
    end

    logic signed [ACC_W-1:0] sum;
    logic                    sum_ovf;

    mac_sat_add #(
        .ACC_W (ACC_W),
        .WGT_W (WGT_W)
    ) u_sat_add (
        .en     (spike_in),
        .acc    (acc_in),
        .weight (weight),
        .sum    (sum),
        .ovf    (sum_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out <= '0;
            ovf     <= 1'b0;
        end else begin
            acc_out <= sum;
            ovf     <= sum_ovf;
        end
    end

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: integer reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_mac;

    logic               clk;
    logic               rst;
    logic               spike_in;
    logic signed [7:0]  weight;
    logic signed [15:0] acc_in;
    logic signed [15:0] acc_out;
    logic               ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_out = 0;
    int exp_ovf = 0;
    bit check_en = 1'b0;

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    mac #(
        .ACC_W (16),
        .WGT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spike_in (spike_in),
        .weight   (weight),
        .acc_in   (acc_in),
        .acc_out  (acc_out),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true integer sum, then clamp or fold into the 16-bit range.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_out <= 0;
            exp_ovf <= 0;
        end else begin
            int t;
            t = spike_in ? int'(acc_in) + int'(weight) : int'(acc_in);
            exp_ovf <= (t > 32767 || t < -32768) ? 1 : 0;
            if (SAT) exp_out <= (t > 32767) ? 32767 : (t < -32768) ? -32768 : t;
            else     exp_out <= (t > 32767) ? t - 65536 : (t < -32768) ? t + 65536 : t;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_acc", int'(acc_out), exp_out);
            chk("model_ovf", int'(ovf), exp_ovf);
        end
    end

    task automatic apply(input logic sp, input int w, input int a);
        spike_in = sp;
        weight   = 8'(w);
        acc_in   = 16'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int acc, input int o);
        chk({name, "_acc"}, int'(acc_out), acc);
        chk({name, "_ovf"}, int'(ovf), o);
    endtask

    initial begin
        rst      = 1'b1;
        spike_in = 1'b1;
        weight   = 8'sd5;
        acc_in   = 16'sd100;
        #1 rst = 1'b0;
        check_en = 1'b1;

        // Reset held 10 ns with changing inputs: outputs stay at zero throughout.
        for (int i = 0; i < 5; i++) begin
            #1 expect_out("reset_hold", 0, 0);
            spike_in = 1'b1;
            weight   = 8'($urandom);
            acc_in   = 16'($urandom);
            #1;
        end
        #1 rst = 1'b1;

        apply(1'b0, 3, 10);          expect_out("pass_10", 10, 0);
        apply(1'b1, 3, 10);          expect_out("add_13", 13, 0);
        apply(1'b1, -2, 13);         expect_out("dec_11", 11, 0);
        apply(1'b0, -2, 13);         expect_out("pass_13", 13, 0);
        apply(1'b1, 1, 32767);       expect_out("pos_ovf", SAT ? 32767 : -32768, 1);
        apply(1'b1, -1, -32768);     expect_out("neg_ovf", SAT ? -32768 : 32767, 1);
        apply(1'b1, 127, 32700);     expect_out("pos_ovf_big", SAT ? 32767 : -32709, 1);
        apply(1'b1, -128, -32700);   expect_out("neg_ovf_big", SAT ? -32768 : 32708, 1);
        apply(1'b1, 1, 32766);       expect_out("pos_edge", 32767, 0);
        apply(1'b1, -1, -32767);     expect_out("neg_edge", -32768, 0);
        apply(1'b1, -128, 32767);    expect_out("mixed_pos", 32639, 0);
        apply(1'b1, 127, -32768);    expect_out("mixed_neg", -32641, 0);
        apply(1'b0, -1, -32768);     expect_out("pass_min", -32768, 0);

        // Mid-cycle reset during back-to-back spikes.
        apply(1'b1, 5, 100);         expect_out("b2b_1", 105, 0);
        apply(1'b1, 5, 105);         expect_out("b2b_2", 110, 0);
        #1 rst = 1'b0;
        #1 expect_out("async_rst", 0, 0);
        spike_in = 1'b1;
        weight   = 8'sd7;
        acc_in   = 16'sd200;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 expect_out("post_rst", 207, 0);

        for (int i = 0; i < 24; i++) begin
            apply(1'($urandom), int'($signed(8'($urandom))), int'($signed(16'($urandom))));
        end
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
